trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter DEPTH, default 256, total samples per capture record (power of two, 16..4096).
REQ-002 Parameter PRE, default 64, pre-trigger samples per record (1..DEPTH-1).
REQ-003 Parameter HDR, default 8'hA5, record start byte.
REQ-004 clk  in  1  sample clock, shared with the ADC and trigger logic.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ADC_IN  in  14  raw ADC sample, one per clk.
REQ-007 trigger  in  1  trigger level from the trigger detector, high while the trigger condition holds.
REQ-008 arm  in  1  one-cycle request to start a new capture.
REQ-009 tx_data  out  8  byte to the UART transmitter.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  UART transmitter accepts a byte when tx_valid and tx_ready are both high.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 trig_addr  out  log2(DEPTH)  buffer address of the trigger sample, valid from POST onward.

Function
REQ-014 States: IDLE, FILL, ARMED, POST, SEND_HDR, SEND_HI, SEND_LO.
REQ-015 IDLE: no buffer writes; arm moves the block to FILL and clears the fill counter and write pointer.
REQ-016 FILL, ARMED, POST: ADC_IN is written each cycle at the write pointer, which then increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-017 FILL moves to ARMED after exactly PRE writes; trigger edges during FILL are ignored.
REQ-018 ARMED: a rising edge of trigger (current high, previous cycle low) moves the block to POST; a trigger already high on entry to ARMED does not fire.
REQ-019 On the edge cycle, the written sample is the trigger sample; trig_addr latches its address.
REQ-020 POST writes DEPTH-PRE-1 further samples, then moves to SEND_HDR with the read pointer set to (trig_addr-PRE) mod DEPTH.
REQ-021 SEND_HDR presents HDR; on handshake moves to SEND_HI.
REQ-022 SEND_HI presents {2'b00, sample[13:8]}; on handshake moves to SEND_LO.
REQ-023 SEND_LO presents sample[7:0]; on handshake the read pointer increments modulo DEPTH.
REQ-024 After the DEPTH-th low byte handshake the block returns to IDLE.
REQ-025 Byte order is header, then oldest-to-newest samples, MSB byte first; total bytes per record = 1+2*DEPTH.
REQ-026 The buffer uses registered reads; the SEND_HI/SEND_LO pipeline prefetches so tx_valid never drops between bytes when tx_ready stays high (one byte per clk).
REQ-027 tx_valid and tx_data hold stable while tx_valid=1 and tx_ready=0.
REQ-028 arm outside IDLE is ignored; trigger outside ARMED is ignored; no buffer writes occur in SEND_* states.
REQ-029 An arm and a trigger edge in the same IDLE cycle: arm is taken and the trigger is ignored.

Reset
REQ-030 rst forces IDLE; tx_valid=0, tx_data=0, busy=0, trig_addr=0, write/read pointers=0, counters=0, previous-trigger register=0.
REQ-031 rst mid-record (any state) aborts it at the next edge; no further bytes are presented; buffer contents are don't-care.

Structure
REQ-032 Package trigger_capture_pkg holds the state enum, the HDR default, and the byte-format field widths.
REQ-033 Sub-module trigger_capture_ram: simple dual-port DEPTH x 14 RAM, one write port, one registered read port, inferable as Cyclone V M10K.

Verification (DEPTH=16, PRE=4, ADC_IN = ramp 0,1,2,... from reset release)
REQ-034 arm at cycle 0, trigger edge at ramp value 20, tx_ready=1 -> bytes A5, then samples 16..31 as 00/10,00/11,...,00/1F; 33 bytes total; busy falls afterwards.
REQ-035 trigger held high before and across the ARMED entry -> no capture until trigger falls and rises again; captured trigger sample = value at the second rise.
REQ-036 tx_ready toggled 1,0,1,0 during readout -> byte sequence identical to REQ-034, no duplicates or drops, tx_data stable while stalled.
REQ-037 Trigger edge where the write pointer sits at 2 -> pre-trigger region wraps (addresses 14,15,0,1); bytes still oldest-first; trig_addr=2.
REQ-038 ADC_IN=14'h3FFF at the trigger -> bytes 3F, FF for that sample.
REQ-039 rst asserted during SEND_HI -> tx_valid=0 next cycle, state IDLE; a new arm produces a complete correct record.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// Shared types and byte-format constants for the trigger capture block.
// Pure declarations; no latency or flow control involved.
package trigger_capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_SEND_HDR,
        S_SEND_HI,
        S_SEND_LO
    } state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         SAMPLE_W    = 14;
    localparam int         BYTE_W      = 8;
    // Zero bits padded above the sample MSBs in the high byte.
    localparam int         HI_PAD      = 2 * BYTE_W - SAMPLE_W;

endpackage

// File: rtl/trigger_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read data appears one clk after the address; no flow control.
module trigger_capture_ram
    import trigger_capture_pkg::*;
#(
    parameter int  DEPTH = 256,
    parameter int  WIDTH = SAMPLE_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // No reset on the array or read register so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger ADC capture into a ring buffer, then serialised as header + MSB/LSB byte pairs.
// One byte per clk while tx_ready stays high; tx_valid/tx_data hold while stalled.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int         DEPTH = 256,
    parameter int         PRE   = 64,
    parameter logic [7:0] HDR   = HDR_DEFAULT,
    localparam int        AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] ADC_IN,
    input  logic                trigger,
    input  logic                arm,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [AW-1:0]       trig_addr
);

    localparam int            POST_N    = DEPTH - PRE - 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST = (POST_N > 0) ? AW'(POST_N - 1) : '0;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] REC_LAST  = AW'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW-1:0]       r_trig_addr;
    logic                r_trig_prev;
    logic                w_edge;
    logic                w_hs;
    logic                w_we;
    logic [AW-1:0]       w_raddr;
    logic [SAMPLE_W-1:0] w_rdata;

    assign w_edge    = trigger & ~r_trig_prev;
    assign w_hs      = tx_valid & tx_ready;
    assign busy      = (r_state != S_IDLE);
    assign trig_addr = r_trig_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        case (r_state)
            S_IDLE:     if (arm) w_next_state = S_FILL;
            S_FILL: begin
                w_we = 1'b1;
                if (r_cnt == PRE_LAST) w_next_state = S_ARMED;
            end
            S_ARMED: begin
                w_we = 1'b1;
                if (w_edge) w_next_state = (POST_N == 0) ? S_SEND_HDR : S_POST;
            end
            S_POST: begin
                w_we = 1'b1;
                if (r_cnt == POST_LAST) w_next_state = S_SEND_HDR;
            end
            S_SEND_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (w_hs) w_next_state = S_SEND_HI;
            end
            S_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = {{HI_PAD{1'b0}}, w_rdata[SAMPLE_W-1:BYTE_W]};
                if (w_hs) w_next_state = S_SEND_LO;
            end
            S_SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = w_rdata[BYTE_W-1:0];
                if (w_hs) w_next_state = (r_cnt == REC_LAST) ? S_IDLE : S_SEND_HI;
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Prefetch the next sample on the low-byte handshake so the following
    // high byte is ready without a bubble; otherwise hold the address so the
    // registered read data stays stable during a stall.
    assign w_raddr = (r_state == S_SEND_LO && w_hs) ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_trig_addr <= '0;
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_prev <= trigger;
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_cnt    <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                S_FILL:  r_cnt <= (r_cnt == PRE_LAST) ? '0 : r_cnt + 1'b1;
                S_ARMED: begin
                    if (w_edge) begin
                        r_trig_addr <= r_wr_ptr;
                        r_rd_ptr    <= r_wr_ptr - PRE_A;
                        r_cnt       <= '0;
                    end
                end
                S_POST:  r_cnt <= (r_cnt == POST_LAST) ? '0 : r_cnt + 1'b1;
                S_SEND_LO: begin
                    if (w_hs) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    trigger_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (ADC_IN),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_trigger_capture.sv
// Directed and randomised capture records checked against a window model over the driven sample history.
module tb_trigger_capture;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int AW    = 4;
    localparam int NB    = 1 + 2 * DEPTH;
    localparam int MAXC  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [13:0]   ADC_IN;
    logic          trigger;
    logic          arm;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic [AW-1:0] trig_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rampv = 0;
    int ready_mode = 0;
    int adc_rand   = 0;
    int a_cyc, first_cyc, last_cyc;
    bit prev_stall = 0;
    logic [7:0] prev_dat;

    logic [13:0] adc_h [MAXC];
    bit          trg_h [MAXC];
    logic [7:0]  got [$];

    always #5 clk = ~clk;

    trigger_capture #(
        .DEPTH (DEPTH),
        .PRE   (PRE),
        .HDR   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ADC_IN    (ADC_IN),
        .trigger   (trigger),
        .arm       (arm),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .trig_addr (trig_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int i);
        return (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
    endfunction

    // One clock: observe at negedge, advance inputs just after posedge.
    task automatic tick();
        @(negedge clk);
        if (cyc < MAXC) begin
            adc_h[cyc] = ADC_IN;
            trg_h[cyc] = trigger;
        end
        if (prev_stall) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(prev_dat));
        end
        prev_stall = tx_valid && !tx_ready && !rst;
        prev_dat   = tx_data;
        if (tx_valid && tx_ready && !rst) begin
            if (got.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            got.push_back(tx_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        rampv++;
        ADC_IN = (adc_rand != 0) ? 14'($urandom) : 14'(rampv);
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        prev_stall = 0;
        tick();
        tick();
        rst = 1'b0;
        rampv = 0;
        ADC_IN = (adc_rand != 0) ? 14'($urandom) : 14'd0;
        got.delete();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        a_cyc = cyc;
        got.delete();
        tick();
        arm = 1'b0;
    endtask

    // Expected record: the first trigger rise once PRE samples are stored
    // selects the window of DEPTH samples starting PRE before it.
    task automatic finish_record(input string tag, input bit gapless);
        int n = 0;
        int c = -1;
        logic [13:0] s;
        while (got.size() < NB && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_count"}, got.size(), NB);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_valid_after"}, 32'(tx_valid), 32'd0);
        for (int k = a_cyc + PRE + 1; k < cyc; k++) begin
            if (trg_h[k] && !trg_h[k-1]) begin
                c = k;
                break;
            end
        end
        check({tag, "_edge_found"}, 32'(c >= 0), 32'd1);
        if (c >= 0) begin
            check({tag, "_taddr"}, 32'(trig_addr), 32'((c - a_cyc - 1) % DEPTH));
            check({tag, "_hdr"}, byte_at(0), 32'hA5);
            for (int i = 0; i < DEPTH; i++) begin
                s = adc_h[c - PRE + i];
                check({tag, "_hi"}, byte_at(1 + 2 * i), {26'd0, s[13:8]});
                check({tag, "_lo"}, byte_at(2 + 2 * i), {24'd0, s[7:0]});
            end
        end
        if (gapless) check({tag, "_gapless"}, last_cyc - first_cyc, NB - 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        tx_ready = 1'b1;
        ADC_IN = '0;

        do_reset();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_taddr", 32'(trig_addr), 32'd0);

        // Ramp record, trigger at value 20; an arm during capture is ignored.
        arm_pulse();
        check("busy_after_arm", 32'(busy), 32'd1);
        repeat (19) tick();
        trigger = 1'b1;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        trigger = 1'b0;
        finish_record("ramp", 1'b1);
        check("ramp_taddr_abs", 32'(trig_addr), 32'd3);

        // Trigger held high across ARMED entry: only the second rise counts.
        trigger = 1'b1;
        repeat (2) tick();
        arm_pulse();
        repeat (PRE + 3) tick();
        trigger = 1'b0;
        repeat (2) tick();
        trigger = 1'b1;
        repeat (2) tick();
        trigger = 1'b0;
        finish_record("held", 1'b1);
        check("held_taddr_abs", 32'(trig_addr), 32'd9);

        // Readout with tx_ready toggling every cycle.
        do_reset();
        arm_pulse();
        repeat (19) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        ready_mode = 1;
        finish_record("toggle", 1'b0);
        ready_mode = 0;
        tx_ready = 1'b1;

        // Trigger at write address 2: pre-trigger region wraps.
        arm_pulse();
        repeat (18) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        finish_record("wrap", 1'b1);
        check("wrap_taddr_abs", 32'(trig_addr), 32'd2);

        // Full-scale trigger sample.
        arm_pulse();
        repeat (10) tick();
        trigger = 1'b1;
        ADC_IN = 14'h3FFF;
        tick();
        trigger = 1'b0;
        finish_record("max", 1'b1);
        check("max_hi", byte_at(1 + 2 * PRE), 32'h3F);
        check("max_lo", byte_at(2 + 2 * PRE), 32'hFF);

        // Reset while presenting a high byte, then a clean record.
        arm_pulse();
        repeat (8) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n = 0;
        while (got.size() < 1 && n < 200) begin
            tick();
            n++;
        end
        check("midrst_in_hi", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(tx_data), 32'd0);
        arm_pulse();
        repeat (12) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        finish_record("after_rst", 1'b1);

        // Random samples, trigger chatter and backpressure; first record also
        // raises trigger in the same IDLE cycle as arm.
        adc_rand = 1;
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            trigger = (r == 0);
            arm_pulse();
            n = $urandom_range(PRE + 1, 30);
            for (int k = 0; k < n; k++) begin
                trigger = ($urandom_range(0, 2) == 0);
                tick();
            end
            trigger = 1'b0;
            tick();
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            finish_record("rand", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
